// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the program counter, fetches instructions over a
// req/ready + rvalid handshake, and presents each fetched instruction for one
// execute window. Computes the next PC from the branch/jump decisions and
// traps (sticky error, HALT) on a misaligned target.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  instr_op,
  output logic [2:0]  instr_func3,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        stall_in,
  input  logic        beq_in,
  input  logic        bne_in,
  input  logic        blt_in,
  input  logic        bge_in,
  input  logic        jal_in,
  input  logic        alu_pc_sel_in,
  input  logic        zero_in,
  input  logic        lt_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] alu_result_in,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EXEC = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        taken;
  logic        misaligned;

  assign imem_addr   = pc;
  assign pc_out      = pc;
  assign pc_plus4    = pc + 32'd4;
  assign instr_op    = instr[6:0];
  assign instr_func3 = instr[14:12];

  // Next-PC selection: jalr target beats jal/taken branch, which beats pc+4.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    taken      = (beq_in & zero_in) | (bne_in & ~zero_in) |
                 (blt_in & lt_in)   | (bge_in & ~lt_in);
    next_pc    = pc + 32'd4;
    if (alu_pc_sel_in) begin
      next_pc = alu_result_in & ~32'h1;
    end else if (jal_in | taken) begin
      next_pc = pc + imm_in;
    end
    misaligned = (next_pc[1:0] != 2'b00);
  end

  // Fetch FSM with registered handshake and execute-window outputs.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ready) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            state       <= EXEC;
            instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall_in) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            if (misaligned) begin
              state <= HALT;
              error <= 1'b1;
            end else begin
              state    <= REQ;
              imem_req <= 1'b1;
            end
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: scoreboard bench for fetch_pc_unit. A driver issues
// branch/jump decisions and predicts fetch addresses with a reference PC
// model; a memory responder supplies random instruction words; monitors pop
// and compare fetch addresses and executed instructions.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum int {K_SEQ, K_BEQ, K_BNE, K_BLT, K_BGE, K_JAL, K_JALR} kind_e;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [6:0]  instr_op;
  logic [2:0]  instr_func3;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        stall_in = 1'b0;
  logic        beq_in = 1'b0, bne_in = 1'b0, blt_in = 1'b0, bge_in = 1'b0;
  logic        jal_in = 1'b0, alu_pc_sel_in = 1'b0;
  logic        zero_in = 1'b0, lt_in = 1'b0;
  logic [31:0] imm_in = 32'h0;
  logic [31:0] alu_result_in = 32'h0;
  logic        error;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_data[$];
  logic [31:0] model_pc;
  logic        mem_auto = 1'b1;
  logic        mem_acc;
  logic        prev_valid = 1'b0;

  fetch_pc_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_op(instr_op), .instr_func3(instr_func3),
    .instr_valid(instr_valid), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .stall_in(stall_in), .beq_in(beq_in), .bne_in(bne_in), .blt_in(blt_in),
    .bge_in(bge_in), .jal_in(jal_in), .alu_pc_sel_in(alu_pc_sel_in),
    .zero_in(zero_in), .lt_in(lt_in), .imm_in(imm_in),
    .alu_result_in(alu_result_in), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Fetch monitor: a request with ready high is accepted at the next edge.
  always @(negedge clk) begin
    if (reset && imem_req && imem_ready) begin
      if (exp_addr.size() == 0) begin
        tests++; fails++;
        $display("FAIL fetch_unexpected: got request at %h, none expected", imem_addr);
      end else begin
        check("fetch_addr", imem_addr, exp_addr.pop_front());
      end
    end
  end

  // Execute monitor: compare the latched instruction at each window start.
  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 1'b0;
    end else begin
      if (instr_valid && !prev_valid) begin
        if (exp_data.size() == 0 || exp_pc.size() == 0) begin
          tests++; fails++;
          $display("FAIL exec_unexpected: got window at pc %h, none expected", pc_out);
        end else begin
          logic [31:0] d;
          logic [31:0] p;
          d = exp_data.pop_front();
          p = exp_pc.pop_front();
          check("instr", instr, d);
          check("instr_op", {25'd0, instr_op}, {25'd0, d[6:0]});
          check("instr_func3", {29'd0, instr_func3}, {29'd0, d[14:12]});
          check("pc_out", pc_out, p);
          check("pc_plus4", pc_plus4, p + 32'd4);
        end
      end
      prev_valid = instr_valid;
    end
  end

  // Memory responder: data returns one cycle after acceptance.
  initial forever begin
    @(negedge clk);
    mem_acc = mem_auto && reset && imem_req && imem_ready;
    @(posedge clk);
    #1;
    if (mem_auto) begin
      imem_rvalid = mem_acc;
      imem_rdata  = $urandom;
      if (mem_acc) exp_data.push_back(imem_rdata);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached");
    fails++;
    finish_tb();
  end

  task automatic flush();
    exp_addr.delete();
    exp_pc.delete();
    exp_data.delete();
  endtask

  // Reset, check reset outputs, release, and check the single IDLE cycle.
  task automatic do_reset();
    reset = 1'b0;
    flush();
    repeat (2) begin @(posedge clk); #1; end
    check("rst_instr", instr, NOP_INSTR);
    check("rst_valid", instr_valid, 0);
    check("rst_req", imem_req, 0);
    check("rst_error", error, 0);
    check("rst_pc", pc_out, RESET_PC);
    model_pc = RESET_PC;
    exp_addr.push_back(RESET_PC);
    exp_pc.push_back(RESET_PC);
    reset = 1'b1;
    @(negedge clk);
    check("idle_req", imem_req, 0);
    @(posedge clk); #1;
    check("req_after_idle", imem_req, 1);
    check("req_addr", imem_addr, RESET_PC);
    check("req_instr_nop", instr, NOP_INSTR);
    check("req_error", error, 0);
  endtask

  task automatic wait_exec(output int cycles);
    cycles = 0;
    while (!instr_valid) begin
      if (cycles >= 30) begin
        fails++;
        $display("FAIL exec_timeout: got no execute window in %0d cycles, expected one", cycles);
        finish_tb();
      end
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  // Drive one execute window and predict the resulting fetch address.
  task automatic exec_instr(input kind_e kind, input logic zero, input logic lt,
                            input logic [31:0] imm, input logic [31:0] alu,
                            input int stall_cycles, output int valid_cycles);
    logic        tk;
    logic [31:0] next;
    case (kind)
      K_BEQ:   tk = zero;
      K_BNE:   tk = !zero;
      K_BLT:   tk = lt;
      K_BGE:   tk = !lt;
      K_JAL:   tk = 1'b1;
      default: tk = 1'b0;
    endcase
    if (kind == K_JALR)  next = {alu[31:1], 1'b0};
    else if (tk)         next = model_pc + imm;
    else                 next = model_pc + 32'd4;

    beq_in = (kind == K_BEQ);  bne_in = (kind == K_BNE);
    blt_in = (kind == K_BLT);  bge_in = (kind == K_BGE);
    jal_in = (kind == K_JAL) || (kind == K_JALR);
    alu_pc_sel_in = (kind == K_JALR);
    zero_in = zero; lt_in = lt; imm_in = imm; alu_result_in = alu;

    valid_cycles = 1;
    if (stall_cycles > 0) begin
      stall_in = 1'b1;
      repeat (stall_cycles) begin
        @(posedge clk); #1;
        if (instr_valid) valid_cycles++;
        check("stall_pc_hold", pc_out, model_pc);
      end
      stall_in = 1'b0;
    end
    @(posedge clk); #1;
    {beq_in, bne_in, blt_in, bge_in, jal_in, alu_pc_sel_in} = '0;
    model_pc = next;
    if (next[1:0] != 2'b00) begin
      check("halt_error", error, 1);
      check("halt_req", imem_req, 0);
      check("halt_valid", instr_valid, 0);
      check("halt_pc", pc_out, next);
    end else begin
      exp_addr.push_back(next);
      exp_pc.push_back(next);
      check("exec_error", error, 0);
      check("exec_valid_drop", instr_valid, 0);
    end
  endtask

  task automatic step(input kind_e kind, input logic zero, input logic lt,
                      input logic [31:0] imm, input logic [31:0] alu);
    int c;
    int v;
    wait_exec(c);
    exec_instr(kind, zero, lt, imm, alu, 0, v);
  endtask

  initial begin
    int c;
    int v;
    do_reset();

    // Straight-line fetch: a window every 3 cycles.
    wait_exec(c);
    exec_instr(K_SEQ, 0, 0, 32'h0, 32'h0, 0, v);
    for (int i = 0; i < 3; i++) begin
      wait_exec(c);
      check("exec_period", c + 1, 3);
      exec_instr(K_SEQ, 0, 0, 32'h0, 32'h0, 0, v);
    end
    // pc = 0x00400010 now; branch cases with imm = -8.
    step(K_BEQ, 1, 0, -32'sd8, 32'h0);          // -> 0x00400008
    step(K_SEQ, 0, 0, 32'h0, 32'h0);
    step(K_SEQ, 0, 0, 32'h0, 32'h0);            // -> 0x00400010
    step(K_BEQ, 0, 0, -32'sd8, 32'h0);          // -> 0x00400014
    step(K_JAL, 0, 0, -32'sd4, 32'h0);          // -> 0x00400010
    step(K_BGE, 0, 0, -32'sd8, 32'h0);          // -> 0x00400008
    step(K_JALR, 0, 0, 32'h0000_0100, 32'h0040_0021);  // -> 0x00400020

    // Stall 3 cycles: window lasts 4 cycles, one pc+4 update.
    wait_exec(c);
    exec_instr(K_SEQ, 0, 0, 32'h0, 32'h0, 3, v);
    check("stall_window_len", v, 4);

    // Wrap-around is not a fault.
    step(K_JALR, 1, 1, 32'h8, 32'hFFFF_FFFD);   // -> 0xFFFFFFFC
    step(K_SEQ, 0, 0, 32'h0, 32'h0);            // -> 0x00000000

    // Randomized legal instruction stream.
    for (int i = 0; i < 40; i++) begin
      kind_e       k;
      logic [31:0] imm;
      logic [31:0] alu;
      k   = kind_e'($urandom_range(0, 6));
      alu = $urandom & ~32'h2;
      imm = ($urandom_range(0, 32) - 16) * 4;
      if (k == K_SEQ || k == K_JALR) imm = $urandom;
      step(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), imm, alu);
    end

    // Ready held low: request and address stay stable.
    step(K_SEQ, 0, 0, 32'h0, 32'h0);
    wait_exec(c);
    exec_instr(K_SEQ, 0, 0, 32'h0, 32'h0, 0, v);
    imem_ready = 1'b0;
    mem_auto   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ready_low_req", imem_req, 1);
      check("ready_low_addr", imem_addr, model_pc);
    end
    @(posedge clk); #1;
    imem_ready = 1'b1;
    @(posedge clk); #1;
    check("wait_req_low", imem_req, 0);
    // Reset in WAIT with a late response: response must be ignored.
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    flush();
    @(posedge clk); #1;
    check("late_rvalid_instr", instr, NOP_INSTR);
    check("late_rvalid_valid", instr_valid, 0);
    @(posedge clk); #1;
    check("late_rvalid_req", imem_req, 0);
    imem_rvalid = 1'b0;
    mem_auto    = 1'b1;
    do_reset();
    step(K_SEQ, 0, 0, 32'h0, 32'h0);
    step(K_BNE, 0, 0, 32'h40, 32'h0);           // -> pc+0x40

    // Misaligned jalr target: trap, HALT, no further requests.
    step(K_JALR, 0, 0, 32'h0, 32'h0040_0022);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("halt_idle", {imem_req, instr_valid}, 0);
    end
    check("error_sticky", error, 1);

    do_reset();
    wait_exec(c);
    stall_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("queues_drained", exp_addr.size() + exp_pc.size() + exp_data.size(), 0);
    finish_tb();
  end

endmodule
